// File: rtl/snr_meter_pkg.sv
// rtl/snr_meter_pkg.sv - shared FSM state, BCD digit count and BCD word type for snr_meter_ctrl
package snr_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } meter_state_t;

    localparam int BCD_DIGITS = 3;

    typedef logic [4*BCD_DIGITS-1:0] bcd_word_t;

endpackage

// File: rtl/snr_bin2bcd.sv
// rtl/snr_bin2bcd.sv - sequential double-dabble, one shift-add-3 step per clock, start/done handshake
module snr_bin2bcd
    import snr_meter_pkg::*;
#(
    parameter int SNR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SNR_WIDTH-1:0] bin,
    output bcd_word_t            bcd,
    output logic                 last_step,
    output logic                 done
);

    localparam int CNT_W = $clog2(SNR_WIDTH + 1);

    logic [SNR_WIDTH-1:0] bin_sr;
    logic [CNT_W-1:0]     steps_left;
    bcd_word_t            bcd_adj;

    // Add-3 correction on every digit that would overflow past 9 after the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // High during the cycle whose closing edge performs the final shift.
    assign last_step = (steps_left == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr     <= '0;
            bcd        <= '0;
            steps_left <= '0;
            done       <= 1'b0;
        end else if (start) begin
            bin_sr     <= bin;
            bcd        <= '0;
            steps_left <= CNT_W'(SNR_WIDTH);
            done       <= 1'b0;
        end else if (steps_left != '0) begin
            bcd        <= {bcd_adj[4*BCD_DIGITS-2:0], bin_sr[SNR_WIDTH-1]};
            bin_sr     <= bin_sr << 1;
            steps_left <= steps_left - CNT_W'(1);
            done       <= last_step;
        end
    end

endmodule

// File: rtl/snr_meter_ctrl.sv
// rtl/snr_meter_ctrl.sv - windowed SNR average with optional peak hold (SNR_PEAK_HOLD_EN), BCD display outputs
module snr_meter_ctrl
    import snr_meter_pkg::*;
#(
    parameter int SNR_WIDTH         = 8,
    parameter int WINDOW_LOG2       = 12,
    parameter int PEAK_HOLD_WINDOWS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SNR_WIDTH-1:0] snr_in,
    input  logic                 snr_valid,
    output logic                 snr_ready,
    input  logic                 freeze,
    output bcd_word_t            avg_bcd,
    output bcd_word_t            peak_bcd,
    output logic                 disp_valid
);

    localparam int ACC_W = SNR_WIDTH + WINDOW_LOG2;

    // A hold length below one window has no meaning; the guard block only
    // exists so such a configuration stands out in the elaborated hierarchy.
    if (PEAK_HOLD_WINDOWS < 1) begin : g_invalid_peak_hold_windows
    end

    meter_state_t state, state_next;

    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_sum;
    logic [WINDOW_LOG2-1:0] count;
    logic [SNR_WIDTH-1:0]   avg_new;
    logic                   accept;
    logic                   window_end;
    logic                   load;

    bcd_word_t avg_conv_bcd;
    logic      avg_last;
    logic      avg_done;
    logic      conv_last;
    logic      conv_done;

    assign accept     = snr_valid && snr_ready;
    assign window_end = accept && (count == '1);
    assign acc_sum    = acc + ACC_W'(snr_in);
    assign avg_new    = SNR_WIDTH'(acc_sum >> WINDOW_LOG2);

    // The converters latch their operand on the window-end edge itself, so the
    // whole CONVERT state is spent shifting.
    snr_bin2bcd #(.SNR_WIDTH(SNR_WIDTH)) u_avg_conv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (window_end),
        .bin       (avg_new),
        .bcd       (avg_conv_bcd),
        .last_step (avg_last),
        .done      (avg_done)
    );

`ifdef SNR_PEAK_HOLD_EN
    localparam int HOLD_W = (PEAK_HOLD_WINDOWS > 1) ? $clog2(PEAK_HOLD_WINDOWS) : 1;

    logic [SNR_WIDTH-1:0] peak, peak_new;
    logic [HOLD_W-1:0]    hold_cnt, hold_new;
    bcd_word_t            peak_conv_bcd;
    logic                 peak_last;
    logic                 peak_done;

    // A new high, or an expired hold, retakes the peak and restarts the hold.
    always_comb begin
        peak_new = peak;
        hold_new = hold_cnt;
        if ((avg_new >= peak) || (hold_cnt == '0)) begin
            peak_new = avg_new;
            hold_new = HOLD_W'(PEAK_HOLD_WINDOWS - 1);
        end else begin
            hold_new = hold_cnt - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak     <= '0;
            hold_cnt <= '0;
        end else if (window_end) begin
            peak     <= peak_new;
            hold_cnt <= hold_new;
        end
    end

    snr_bin2bcd #(.SNR_WIDTH(SNR_WIDTH)) u_peak_conv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (window_end),
        .bin       (peak_new),
        .bcd       (peak_conv_bcd),
        .last_step (peak_last),
        .done      (peak_done)
    );

    assign conv_last = avg_last && peak_last;
    assign conv_done = avg_done && peak_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_bcd <= '0;
        end else if (load) begin
            peak_bcd <= peak_conv_bcd;
        end
    end
`else
    assign conv_last = avg_last;
    assign conv_done = avg_done;
    assign peak_bcd  = '0;
`endif

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (window_end) state_next = CONVERT;
            end
            CONVERT: begin
                if (conv_last) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
                load       = !freeze && conv_done;
            end
            default: state_next = IDLE;
        endcase
    end

    // snr_ready is registered from the next state so it is low during reset
    // and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            snr_ready  <= 1'b0;
            acc        <= '0;
            count      <= '0;
            avg_bcd    <= '0;
            disp_valid <= 1'b0;
        end else begin
            state      <= state_next;
            snr_ready  <= (state_next == IDLE);
            disp_valid <= load;
            if (load) begin
                avg_bcd <= avg_conv_bcd;
            end
            if (accept) begin
                if (window_end) begin
                    acc   <= '0;
                    count <= '0;
                end else begin
                    acc   <= acc_sum;
                    count <= count + WINDOW_LOG2'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_snr_meter_ctrl.sv
// tb/tb_snr_meter_ctrl.sv - directed scoreboard bench for snr_meter_ctrl
module tb_snr_meter_ctrl;
    import snr_meter_pkg::*;

    localparam int SNR_WIDTH         = 8;
    localparam int WINDOW_LOG2       = 2;
    localparam int PEAK_HOLD_WINDOWS = 2;
    localparam int WIN               = 1 << WINDOW_LOG2;
    localparam int LATENCY           = SNR_WIDTH + 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [SNR_WIDTH-1:0] snr_in;
    logic                 snr_valid;
    logic                 snr_ready;
    logic                 freeze;
    bcd_word_t            avg_bcd;
    bcd_word_t            peak_bcd;
    logic                 disp_valid;

    snr_meter_ctrl #(
        .SNR_WIDTH         (SNR_WIDTH),
        .WINDOW_LOG2       (WINDOW_LOG2),
        .PEAK_HOLD_WINDOWS (PEAK_HOLD_WINDOWS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .snr_in     (snr_in),
        .snr_valid  (snr_valid),
        .snr_ready  (snr_ready),
        .freeze     (freeze),
        .avg_bcd    (avg_bcd),
        .peak_bcd   (peak_bcd),
        .disp_valid (disp_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bcd_word_t avg;
        bcd_word_t peak;
        int        cyc;
        int        idx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   m_sum      = 0;
    int   m_cnt      = 0;
    int   m_peak     = 0;
    int   m_hold     = 0;
    int   win_idx    = 0;

    function automatic bcd_word_t to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bcd_word_t peak_exp();
`ifdef SNR_PEAK_HOLD_EN
        return to_bcd(m_peak);
`else
        return '0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Presents one sample, waits for acceptance and updates the reference model.
    task automatic send(input int v);
        int guard = 0;
        int avg;
        snr_valid = 1'b1;
        snr_in    = SNR_WIDTH'(v);
        while (snr_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            check("ready_timeout", {31'd0, snr_ready}, 32'd1);
        end else begin
            m_sum += v;
            m_cnt++;
            if (m_cnt == WIN) begin
                avg = m_sum >> WINDOW_LOG2;
                if (avg >= m_peak || m_hold == 0) begin
                    m_peak = avg;
                    m_hold = PEAK_HOLD_WINDOWS - 1;
                end else begin
                    m_hold--;
                end
                win_idx++;
                if (!freeze) sb.push_back('{to_bcd(avg), peak_exp(), cyc + LATENCY, win_idx});
                m_sum = 0;
                m_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_window(input int a, input int b, input int c, input int d);
        send(a); send(b); send(c); send(d);
        snr_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 4 * LATENCY) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && disp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_disp_valid", {31'd0, disp_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("avg_w%0d", mon_e.idx), avg_bcd, mon_e.avg);
                check($sformatf("peak_w%0d", mon_e.idx), peak_bcd, mon_e.peak);
                check($sformatf("latency_w%0d", mon_e.idx), cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        int        low;
        bcd_word_t held_avg;
        bcd_word_t held_peak;

        rst_n     = 1'b0;
        snr_valid = 1'b0;
        snr_in    = '0;
        freeze    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, snr_ready}, 32'd0);
        check("rst_avg", avg_bcd, 32'h000);
        check("rst_peak", peak_bcd, 32'h000);
        check("rst_disp", {31'd0, disp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, snr_ready}, 32'd1);

        // Basic average, stall length and latency.
        send_window(10, 20, 30, 40);
        low = 0;
        while (snr_ready === 1'b0 && low < 50) begin
            low++;
            @(negedge clk);
        end
        check("ready_low_cycles", low, SNR_WIDTH + 1);
        drain();
        check("avg_basic", avg_bcd, 32'h025);

        // Truncation and full-scale.
        send_window(255, 255, 255, 254);
        drain();
        check("avg_trunc", avg_bcd, 32'h254);
        send_window(255, 255, 255, 255);
        drain();
        check("avg_max", avg_bcd, 32'h255);

        // Peak-hold sequence; the monitor checks peak_bcd against the model.
        send_window(80, 80, 80, 80); drain();
        send_window(30, 30, 30, 30); drain();
        send_window(30, 30, 30, 30); drain();
        send_window(30, 30, 30, 30); drain();
        check("avg_low", avg_bcd, 32'h030);
        send_window(90, 90, 90, 90); drain();
        check("avg_rise", avg_bcd, 32'h090);
        check("peak_rise", peak_bcd, peak_exp());

        // Freeze across a window end: no strobe, outputs hold.
        held_avg  = avg_bcd;
        held_peak = peak_bcd;
        freeze = 1'b1;
        send_window(50, 50, 50, 50);
        repeat (LATENCY + 4) @(negedge clk);
        check("freeze_avg_hold", avg_bcd, held_avg);
        check("freeze_peak_hold", peak_bcd, held_peak);
        freeze = 1'b0;
        send_window(60, 60, 60, 60);
        drain();
        check("avg_after_freeze", avg_bcd, 32'h060);

        // Valid held high through both stalls.
        send(1); send(2); send(3); send(4);
        send(5); send(6); send(7); send(8);
        snr_valid = 1'b0;
        drain();
        check("avg_backpressure", avg_bcd, 32'h006);

        // Reset in the middle of CONVERT.
        send_window(100, 100, 100, 100);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, snr_ready}, 32'd0);
        check("midrst_avg", avg_bcd, 32'h000);
        check("midrst_peak", peak_bcd, 32'h000);
        check("midrst_disp", {31'd0, disp_valid}, 32'd0);
        void'(sb.pop_back());
        m_sum  = 0;
        m_cnt  = 0;
        m_peak = 0;
        m_hold = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (LATENCY + 4) @(negedge clk);
        check("postrst_avg", avg_bcd, 32'h000);
        send_window(4, 8, 12, 16);
        drain();
        check("avg_after_reset", avg_bcd, 32'h010);
        check("peak_after_reset", peak_bcd, peak_exp());

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
